seg_mux_decoder: RTL and testbench

Receive-side decoder for the two-digit time-multiplexed seven-segment display bus driven by the lab top level. It samples `seg` and `seg_power` and waits for the pair to settle, so transition ghosting is rejected. It then converts each active-low segment pattern back to a 4-bit hex value and holds the most recent value of each digit. The block serves as an in-fabric display monitor and as a synthesizable checker in top-level benches.

---
 rtl/seg_mux_decoder.sv | 166 ++++++++++++++++
 tb/tb_seg_mux_decoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_mux_decoder.sv
`default_nettype none
// =============================================================================
// Module      : seg_mux_decoder
// Description : Settles the multiplexed seven-segment bus and decodes each
//               digit back to hex. Error flags built only with SEG_DECODE_ERR_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module seg_mux_decoder #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] seg,
  input  logic [1:0] seg_power,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic       valid,
  output logic       update,
  output logic       bad_pattern,
  output logic       overlap
);

  localparam logic [7:0] C_SETTLE = 8'(SETTLE_CYCLES);
  localparam logic [6:0] C_BLANK  = 7'h7F;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  state_t     r_state_q, w_state_d;
  logic [8:0] r_in_q;
  logic [7:0] r_cnt_q, w_cnt_d;
  logic [3:0] r_digit0_q, r_digit1_q;
  logic [1:0] r_seen_q;
  logic       r_update_q;

  logic [8:0] w_in;
  logic       w_changed;
  logic       w_stable;
  logic       w_onehot;
  logic       w_blank;
  logic       w_dec_ok;
  logic [3:0] w_dec;
  logic       w_capture;

  assign w_in      = {seg_power, seg};
  assign w_changed = (w_in != r_in_q);
  assign w_stable  = !w_changed && (r_cnt_q == C_SETTLE);
  assign w_onehot  = (r_in_q[8:7] == 2'b01) || (r_in_q[8:7] == 2'b10);
  assign w_blank   = (r_in_q[6:0] == C_BLANK);

  always_comb begin
    w_cnt_d = r_cnt_q;
    if (w_changed) begin
      w_cnt_d = 8'd1;
    end else if (r_cnt_q < C_SETTLE) begin
      w_cnt_d = r_cnt_q + 8'd1;
    end
  end

  // Standard active-low hex glyphs, lowercase b and d
  always_comb begin
    w_dec    = 4'h0;
    w_dec_ok = 1'b1;
    case (r_in_q[6:0])
      7'h40:   w_dec = 4'h0;
      7'h79:   w_dec = 4'h1;
      7'h24:   w_dec = 4'h2;
      7'h30:   w_dec = 4'h3;
      7'h19:   w_dec = 4'h4;
      7'h12:   w_dec = 4'h5;
      7'h02:   w_dec = 4'h6;
      7'h78:   w_dec = 4'h7;
      7'h00:   w_dec = 4'h8;
      7'h10:   w_dec = 4'h9;
      7'h08:   w_dec = 4'hA;
      7'h03:   w_dec = 4'hB;
      7'h46:   w_dec = 4'hC;
      7'h21:   w_dec = 4'hD;
      7'h06:   w_dec = 4'hE;
      7'h0E:   w_dec = 4'hF;
      default: w_dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_state_d = r_state_q;
    w_capture = 1'b0;
    if (w_changed) begin
      w_state_d = ST_WAIT;
    end else begin
      case (r_state_q)
        ST_WAIT: begin
          if (w_stable && w_onehot && !w_blank && w_dec_ok) begin
            w_state_d = ST_CAPTURE;
            w_capture = 1'b1;
          end
        end
        ST_CAPTURE: w_state_d = ST_HOLD;
        ST_HOLD:    w_state_d = ST_HOLD;
        default:    w_state_d = ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state_q  <= ST_WAIT;
      r_in_q     <= 9'd0;
      r_cnt_q    <= 8'd0;
      r_digit0_q <= 4'h0;
      r_digit1_q <= 4'h0;
      r_seen_q   <= 2'b00;
      r_update_q <= 1'b0;
    end else begin
      r_state_q  <= w_state_d;
      r_in_q     <= w_in;
      r_cnt_q    <= w_cnt_d;
      r_update_q <= w_capture;
      if (w_capture) begin
        if (r_in_q[7]) begin
          r_digit0_q  <= w_dec;
          r_seen_q[0] <= 1'b1;
        end else begin
          r_digit1_q  <= w_dec;
          r_seen_q[1] <= 1'b1;
        end
      end
    end
  end

  assign digit0 = r_digit0_q;
  assign digit1 = r_digit1_q;
  assign valid  = r_seen_q[0] & r_seen_q[1];
  assign update = r_update_q;

`ifdef SEG_DECODE_ERR_EN
  logic r_bad_q;
  logic r_ovl_q;

  // Overlap looks at the registered sample, so it lands one edge after 2'b11
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bad_q <= 1'b0;
      r_ovl_q <= 1'b0;
    end else begin
      if (w_stable && w_onehot && !w_blank && !w_dec_ok) begin
        r_bad_q <= 1'b1;
      end
      if (r_in_q[8:7] == 2'b11) begin
        r_ovl_q <= 1'b1;
      end
    end
  end

  assign bad_pattern = r_bad_q;
  assign overlap     = r_ovl_q;
`else
  assign bad_pattern = 1'b0;
  assign overlap     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg_mux_decoder.sv
`default_nettype none
// =============================================================================
// Module      : tb_seg_mux_decoder
// Description : Randomized bench for seg_mux_decoder against a run-length
//               reference model, plus directed scenarios with literal checks.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_seg_mux_decoder;

  localparam int S = 4;
`ifdef SEG_DECODE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] seg = 7'h00;
  logic [1:0] seg_power = 2'b00;
  logic [3:0] digit0, digit1;
  logic       valid, update, bad_pattern, overlap;

  int n_tests = 0;
  int n_fail  = 0;
  int n_updates = 0;

  seg_mux_decoder #(.SETTLE_CYCLES(S)) dut (
    .clock      (clock),
    .reset      (reset),
    .seg        (seg),
    .seg_power  (seg_power),
    .digit0     (digit0),
    .digit1     (digit1),
    .valid      (valid),
    .update     (update),
    .bad_pattern(bad_pattern),
    .overlap    (overlap)
  );

  always #5 clock = ~clock;

  // Active-low glyphs indexed by hex value
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic int model_decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) begin
      if (glyph[i] == p) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a capture happens on the edge where the same input has
  // been seen on S+1 consecutive edges since reset or the last change.
  int         m_run;
  logic [8:0] m_prev;
  logic       m_first;
  logic [3:0] m_d0, m_d1;
  logic       m_s0, m_s1, m_upd, m_bad, m_ovl, m_ovl_pend;

  always @(posedge clock or negedge reset) begin
    logic [8:0] cur;
    int         v;
    if (!reset) begin
      m_run = 0; m_prev = '0; m_first = 1'b1;
      m_d0 = '0; m_d1 = '0; m_s0 = 0; m_s1 = 0;
      m_upd = 0; m_bad = 0; m_ovl = 0; m_ovl_pend = 0;
    end else begin
      cur   = {seg_power, seg};
      m_upd = 1'b0;
      if (m_ovl_pend && ERR_EN) m_ovl = 1'b1;
      m_ovl_pend = (seg_power == 2'b11);
      if (m_first || cur != m_prev) m_run = 1;
      else if (m_run < 1000)        m_run++;
      m_first = 1'b0;
      m_prev  = cur;
      if (m_run == S + 1 && (seg_power == 2'b01 || seg_power == 2'b10) && seg != 7'h7F) begin
        v = model_decode(seg);
        if (v < 0) begin
          if (ERR_EN) m_bad = 1'b1;
        end else begin
          m_upd = 1'b1;
          if (seg_power == 2'b01) begin m_d0 = v[3:0]; m_s0 = 1'b1; end
          else                    begin m_d1 = v[3:0]; m_s1 = 1'b1; end
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("digit0",      {4'h0, digit0},      {4'h0, m_d0});
    chk("digit1",      {4'h0, digit1},      {4'h0, m_d1});
    chk("valid",       {7'h0, valid},       {7'h0, m_s0 & m_s1});
    chk("update",      {7'h0, update},      {7'h0, m_upd});
    chk("bad_pattern", {7'h0, bad_pattern}, {7'h0, m_bad});
    chk("overlap",     {7'h0, overlap},     {7'h0, m_ovl});
    if (update === 1'b1) n_updates++;
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic apply(input logic [1:0] p, input logic [6:0] s, input int n);
    seg_power = p;
    seg       = s;
    repeat (n) tick();
  endtask

  initial begin
    int         u0;
    logic [1:0] p;
    logic [6:0] s;

    // 1: reset with arbitrary inputs, then digit 1 on the right
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seg_power = 2'($urandom);
      seg       = 7'($urandom);
      tick();
    end
    chk("rst_digit0", {4'h0, digit0}, 8'h00);
    chk("rst_valid",  {7'h0, valid},  8'h00);
    chk("rst_flags",  {6'h0, bad_pattern, overlap}, 8'h00);
    seg_power = 2'b01;
    seg       = 7'b1111001;
    reset     = 1'b1;
    repeat (S + 1) tick();
    chk("s1_digit0", {4'h0, digit0}, 8'h01);
    chk("s1_update", {7'h0, update}, 8'h01);
    chk("s1_valid",  {7'h0, valid},  8'h00);
    tick();
    chk("s1_update_low", {7'h0, update}, 8'h00);

    // 2: alternate digits, one update per hold segment
    u0 = n_updates;
    for (int k = 0; k < 2; k++) begin
      apply(2'b01, 7'b0010010, 20);
      apply(2'b10, 7'b0001000, 20);
    end
    chk("s2_digit0",  {4'h0, digit0}, 8'h05);
    chk("s2_digit1",  {4'h0, digit1}, 8'h0A);
    chk("s2_valid",   {7'h0, valid},  8'h01);
    chk("s2_updates", 8'(n_updates - u0), 8'd4);
    chk("s2_model_d1", {4'h0, m_d1}, 8'h0A);

    // 3: glitch inside settle window
    u0 = n_updates;
    apply(2'b10, 7'b0000000, 3);
    apply(2'b10, 7'b0001110, 1);
    apply(2'b10, 7'b0000000, 3);
    chk("s3_digit1",  {4'h0, digit1}, 8'h0A);
    chk("s3_updates", 8'(n_updates - u0), 8'd0);

    // 4: undecodable settled pattern
    apply(2'b01, 7'b0110110, 10);
    chk("s4_bad",    {7'h0, bad_pattern}, {7'h0, ERR_EN});
    chk("s4_digit0", {4'h0, digit0}, 8'h05);

    // 5: overlap, then settled blank power
    u0 = n_updates;
    apply(2'b11, 7'b1000000, 1);
    apply(2'b00, 7'b1000000, 10);
    chk("s5_overlap", {7'h0, overlap}, {7'h0, ERR_EN});
    chk("s5_updates", 8'(n_updates - u0), 8'd0);

    // 6: reset during settling, capture only after a full window
    apply(2'b01, 7'b0001110, 2);
    reset = 1'b0;
    #1;
    chk("s6_async_digit0", {4'h0, digit0}, 8'h00);
    chk("s6_async_valid",  {7'h0, valid},  8'h00);
    chk("s6_async_flags",  {6'h0, bad_pattern, overlap}, 8'h00);
    tick();
    reset = 1'b1;
    repeat (S) tick();
    chk("s6_digit0_early", {4'h0, digit0}, 8'h00);
    tick();
    chk("s6_digit0", {4'h0, digit0}, 8'h0F);
    chk("s6_model_d0", {4'h0, m_d0}, 8'h0F);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      int kind, pw;
      kind = int'($urandom_range(0, 9));
      pw   = int'($urandom_range(0, 9));
      if (kind <= 5)      s = glyph[$urandom_range(0, 15)];
      else if (kind == 6) s = 7'h7F;
      else if (kind == 7) s = 7'($urandom);
      else                s = 7'h36;
      if (pw <= 3)      p = 2'b01;
      else if (pw <= 7) p = 2'b10;
      else if (pw == 8) p = 2'b00;
      else              p = 2'b11;
      apply(p, s, int'($urandom_range(1, 8)));
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
